// File: rtl/wb_ram_responder.sv
// Pipelined Wishbone B4 RAM slave with per-request wait states.
// Optional macro WB_RAM_WAIT_EN enables the 2-entry queue, wait counter and stall.
module wb_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_accept;
  logic                  w_fire;
  logic                  w_fire_we;
  logic [ADDR_WIDTH-1:0] w_fire_idx;
  logic [31:0]           w_fire_data;
  logic                  w_unused;

  assign w_idx    = i_wb_addr[ADDR_WIDTH+1:2];
  assign w_unused = ^{i_wb_addr[31:ADDR_WIDTH+2], i_wb_addr[1:0], 4'(WAIT_STATES)};

`ifdef WB_RAM_WAIT_EN
  logic [1:0]            r_count;
  logic [3:0]            r_wait;
  logic                  r_q_we   [2];
  logic [ADDR_WIDTH-1:0] r_q_idx  [2];
  logic [31:0]           r_q_data [2];
  logic                  w_complete;
  logic                  w_wr_slot;

  assign o_wb_stall  = (r_count == 2'd2);
  assign w_accept    = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign w_complete  = (r_count != 2'd0) && (r_wait == 4'(WAIT_STATES));
  // A simultaneous completion shifts the queue, so the new entry lands one slot lower.
  assign w_wr_slot   = (r_count == 2'd1) && !w_complete;
  assign w_fire      = w_complete & i_wb_cyc;
  assign w_fire_we   = r_q_we[0];
  assign w_fire_idx  = r_q_idx[0];
  assign w_fire_data = r_q_data[0];

  always_ff @(posedge wb_clk) begin
    if (wb_rst || !i_wb_cyc) begin
      r_count <= '0;
      r_wait  <= '0;
    end else begin
      r_count <= r_count + {1'b0, w_accept} - {1'b0, w_complete};
      r_wait  <= (w_complete || r_count == 2'd0) ? '0 : r_wait + 4'd1;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (w_complete) begin
      r_q_we[0]   <= r_q_we[1];
      r_q_idx[0]  <= r_q_idx[1];
      r_q_data[0] <= r_q_data[1];
    end
    if (w_accept) begin
      r_q_we[w_wr_slot]   <= i_wb_we;
      r_q_idx[w_wr_slot]  <= w_idx;
      r_q_data[w_wr_slot] <= i_wb_data;
    end
  end
`else
  assign o_wb_stall  = 1'b0;
  assign w_accept    = i_wb_cyc & i_wb_stb;
  assign w_fire      = w_accept;
  assign w_fire_we   = i_wb_we;
  assign w_fire_idx  = w_idx;
  assign w_fire_data = i_wb_data;
`endif

  // Memory changes only when a request retires; contents survive reset.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst && w_fire && w_fire_we)
      r_mem[w_fire_idx] <= w_fire_data;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack  <= w_fire;
      o_wb_data <= (w_fire && !w_fire_we) ? r_mem[w_fire_idx] : '0;
    end
  end

endmodule
